fat32_boot_sector_parser: RTL and testbench

FAT32_BOOT_SECTOR_PARSER -- requirements
Module: fat32_boot_sector_parser

---
 rtl/fat32_boot_sector_parser.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_fat32_boot_sector_parser.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fat32_boot_sector_parser.sv
// FAT32 mount sequencer: reads sector 0 (MBR or bare boot sector), then the BPB, and derives the
// absolute FAT and root/data LBAs. Define FAT32_SIGNATURE_CHECK_EN to validate 0x55AA and 512 B/s.
module fat32_boot_sector_parser #(
   parameter int unsigned PARTITION_INDEX = 0,
   parameter int unsigned LBA_WIDTH       = 32
) (
   input  logic                 Clock,
   input  logic                 sys_rst_n,
   input  logic                 start,
   input  logic                 byte_valid,
   input  logic [8:0]           byte_addr,
   input  logic [7:0]           byte_data,
   input  logic                 sector_done,
   output logic                 read_req,
   output logic [LBA_WIDTH-1:0] read_lba,
   output logic [LBA_WIDTH-1:0] partition_lba,
   output logic [LBA_WIDTH-1:0] fat_lba,
   output logic [LBA_WIDTH-1:0] root_dir_lba,
   output logic [7:0]           sectors_per_cluster,
   output logic [31:0]          root_cluster,
   output logic                 ready,
   output logic                 error,
   output logic [1:0]           err_code
);

   typedef enum logic [2:0] {
      StIdle, StReqS0, StRdS0, StReqBpb, StRdBpb, StCalc, StDone, StErr
   } state_e;

   // Offset of the LBA-start field inside the selected partition table entry.
   localparam logic [8:0] PartOff = 9'(446 + 16 * PARTITION_INDEX + 8);

   state_e               state_q, state_d;
   logic [7:0]           byte0_q, byte0_d;
   logic [31:0]          part_raw_q, part_raw_d;
   logic [7:0]           spc_q, spc_d;
   logic [7:0]           nfat_q, nfat_d;
   logic [15:0]          rsvd_q, rsvd_d;
   logic [31:0]          fatsz_q, fatsz_d;
   logic [31:0]          rootc_q, rootc_d;
`ifdef FAT32_SIGNATURE_CHECK_EN
   logic [15:0]          bps_q, bps_d;
   logic [7:0]           sig_lo_q, sig_lo_d;
   logic [7:0]           sig_hi_q, sig_hi_d;
`endif
   logic                 read_req_q, read_req_d;
   logic [LBA_WIDTH-1:0] read_lba_q, read_lba_d;
   logic [LBA_WIDTH-1:0] part_lba_q, part_lba_d;
   logic [LBA_WIDTH-1:0] fat_lba_q, fat_lba_d;
   logic [LBA_WIDTH-1:0] root_lba_q, root_lba_d;
   logic                 ready_q, ready_d;
   logic                 error_q, error_d;
   logic [1:0]           err_q, err_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [LBA_WIDTH-1:0] mcand_q, mcand_d;
   logic [LBA_WIDTH-1:0] prod_q, prod_d;
   logic [7:0]           mplier_q, mplier_d;

   logic                 cap_en;
   logic [8:0]           part_rel;
   logic                 is_boot_sector;
   logic                 end_bpb;
   logic [1:0]           s0_err;
   logic [1:0]           bpb_err;

   // Byte capture; the *_d values already include a byte arriving with sector_done.
   always_comb begin
      byte0_d    = byte0_q;
      part_raw_d = part_raw_q;
      spc_d      = spc_q;
      nfat_d     = nfat_q;
      rsvd_d     = rsvd_q;
      fatsz_d    = fatsz_q;
      rootc_d    = rootc_q;
`ifdef FAT32_SIGNATURE_CHECK_EN
      bps_d      = bps_q;
      sig_lo_d   = sig_lo_q;
      sig_hi_d   = sig_hi_q;
      if (state_q == StReqS0 || state_q == StReqBpb) begin
         sig_lo_d = 8'h00;
         sig_hi_d = 8'h00;
      end
`endif
      cap_en   = byte_valid && (state_q == StRdS0 || state_q == StRdBpb);
      part_rel = byte_addr - PartOff;
      if (cap_en) begin
         case (byte_addr)
            9'h000: byte0_d        = byte_data;
            9'h00D: spc_d          = byte_data;
            9'h00E: rsvd_d[7:0]    = byte_data;
            9'h00F: rsvd_d[15:8]   = byte_data;
            9'h010: nfat_d         = byte_data;
            9'h024: fatsz_d[7:0]   = byte_data;
            9'h025: fatsz_d[15:8]  = byte_data;
            9'h026: fatsz_d[23:16] = byte_data;
            9'h027: fatsz_d[31:24] = byte_data;
            9'h02C: rootc_d[7:0]   = byte_data;
            9'h02D: rootc_d[15:8]  = byte_data;
            9'h02E: rootc_d[23:16] = byte_data;
            9'h02F: rootc_d[31:24] = byte_data;
`ifdef FAT32_SIGNATURE_CHECK_EN
            9'h00B: bps_d[7:0]     = byte_data;
            9'h00C: bps_d[15:8]    = byte_data;
            9'h1FE: sig_lo_d       = byte_data;
            9'h1FF: sig_hi_d       = byte_data;
`endif
            default: ;
         endcase
         if (state_q == StRdS0 && part_rel < 9'd4) begin
            part_raw_d[{part_rel[1:0], 3'b000} +: 8] = byte_data;
         end
      end
   end

   // Sector verdicts; later assignments take priority (signature, then bytes/sector, then fields).
   always_comb begin
      is_boot_sector = (byte0_d == 8'hEB) || (byte0_d == 8'hE9);
      s0_err         = 2'b00;
      bpb_err        = 2'b00;
      if (nfat_d == 8'd0 || spc_d == 8'd0) bpb_err = 2'b11;
`ifdef FAT32_SIGNATURE_CHECK_EN
      if (bps_d != 16'd512) bpb_err = 2'b10;
      if (sig_lo_d != 8'h55 || sig_hi_d != 8'hAA) begin
         s0_err  = 2'b01;
         bpb_err = 2'b01;
      end
`endif
   end

   always_comb begin
      state_d    = state_q;
      read_req_d = 1'b0;
      read_lba_d = read_lba_q;
      part_lba_d = part_lba_q;
      fat_lba_d  = fat_lba_q;
      root_lba_d = root_lba_q;
      ready_d    = ready_q;
      error_d    = error_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      prod_d     = prod_q;
      end_bpb    = 1'b0;
      if (start) begin
         state_d = StReqS0;
         ready_d = 1'b0;
         error_d = 1'b0;
         err_d   = 2'b00;
      end else begin
         unique case (state_q)
            StIdle: ;
            StReqS0: begin
               read_req_d = 1'b1;
               read_lba_d = '0;
               state_d    = StRdS0;
            end
            StRdS0: begin
               if (sector_done) begin
                  if (is_boot_sector) begin
                     part_lba_d = '0;
                     end_bpb    = 1'b1;
                  end else if (s0_err != 2'b00) begin
                     state_d = StErr;
                     error_d = 1'b1;
                     err_d   = s0_err;
                  end else begin
                     part_lba_d = LBA_WIDTH'(part_raw_d);
                     state_d    = StReqBpb;
                  end
               end
            end
            StReqBpb: begin
               read_req_d = 1'b1;
               read_lba_d = part_lba_q;
               state_d    = StRdBpb;
            end
            StRdBpb: begin
               if (sector_done) end_bpb = 1'b1;
            end
            StCalc: begin
               // Eight shift-add steps over the FAT-count bits, then one cycle for the sums.
               if (cnt_q != 4'd8) begin
                  if (mplier_q[0]) prod_d = prod_q + mcand_q;
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
                  cnt_d    = cnt_q + 4'd1;
               end else begin
                  fat_lba_d  = part_lba_q + LBA_WIDTH'(rsvd_q);
                  root_lba_d = part_lba_q + LBA_WIDTH'(rsvd_q) + prod_q;
                  state_d    = StDone;
               end
            end
            StDone: ready_d = 1'b1;
            StErr: begin
               error_d = 1'b1;
               ready_d = 1'b0;
            end
         endcase
         if (end_bpb) begin
            if (bpb_err != 2'b00) begin
               state_d = StErr;
               error_d = 1'b1;
               err_d   = bpb_err;
            end else begin
               state_d  = StCalc;
               cnt_d    = 4'd0;
               mcand_d  = LBA_WIDTH'(fatsz_d);
               mplier_d = nfat_d;
               prod_d   = '0;
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= StIdle;
         byte0_q    <= 8'h00;
         part_raw_q <= 32'h0;
         spc_q      <= 8'h00;
         nfat_q     <= 8'h00;
         rsvd_q     <= 16'h0;
         fatsz_q    <= 32'h0;
         rootc_q    <= 32'h0;
`ifdef FAT32_SIGNATURE_CHECK_EN
         bps_q      <= 16'h0;
         sig_lo_q   <= 8'h00;
         sig_hi_q   <= 8'h00;
`endif
         read_req_q <= 1'b0;
         read_lba_q <= '0;
         part_lba_q <= '0;
         fat_lba_q  <= '0;
         root_lba_q <= '0;
         ready_q    <= 1'b0;
         error_q    <= 1'b0;
         err_q      <= 2'b00;
         cnt_q      <= 4'd0;
         mcand_q    <= '0;
         mplier_q   <= 8'h00;
         prod_q     <= '0;
      end else begin
         state_q    <= state_d;
         byte0_q    <= byte0_d;
         part_raw_q <= part_raw_d;
         spc_q      <= spc_d;
         nfat_q     <= nfat_d;
         rsvd_q     <= rsvd_d;
         fatsz_q    <= fatsz_d;
         rootc_q    <= rootc_d;
`ifdef FAT32_SIGNATURE_CHECK_EN
         bps_q      <= bps_d;
         sig_lo_q   <= sig_lo_d;
         sig_hi_q   <= sig_hi_d;
`endif
         read_req_q <= read_req_d;
         read_lba_q <= read_lba_d;
         part_lba_q <= part_lba_d;
         fat_lba_q  <= fat_lba_d;
         root_lba_q <= root_lba_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         prod_q     <= prod_d;
      end
   end

   assign read_req            = read_req_q;
   assign read_lba            = read_lba_q;
   assign partition_lba       = part_lba_q;
   assign fat_lba             = fat_lba_q;
   assign root_dir_lba        = root_lba_q;
   assign sectors_per_cluster = spc_q;
   assign root_cluster        = rootc_q;
   assign ready               = ready_q;
   assign error               = error_q;
   assign err_code            = err_q;

endmodule

// File: tb/tb_fat32_boot_sector_parser.sv
// Scoreboard bench: expected read LBAs and mount results are queued as each run is set up and
// popped when the parser issues a read or finishes.
module tb_fat32_boot_sector_parser;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        start2;
   logic        byte_valid;
   logic [8:0]  byte_addr;
   logic [7:0]  byte_data;
   logic        sector_done;

   logic        read_req,  read_req2;
   logic [31:0] read_lba,  read_lba2;
   logic [31:0] part_lba,  part_lba2;
   logic [31:0] fat_lba,   fat_lba2;
   logic [31:0] root_lba,  root_lba2;
   logic [7:0]  spc,       spc2;
   logic [31:0] rootc,     rootc2;
   logic        ready,     ready2;
   logic        error,     error2;
   logic [1:0]  err_code,  err_code2;

   fat32_boot_sector_parser #(.PARTITION_INDEX(0), .LBA_WIDTH(32)) dut (
      .Clock(clk), .sys_rst_n(rst_n), .start(start), .byte_valid(byte_valid),
      .byte_addr(byte_addr), .byte_data(byte_data), .sector_done(sector_done),
      .read_req(read_req), .read_lba(read_lba), .partition_lba(part_lba), .fat_lba(fat_lba),
      .root_dir_lba(root_lba), .sectors_per_cluster(spc), .root_cluster(rootc),
      .ready(ready), .error(error), .err_code(err_code)
   );

   fat32_boot_sector_parser #(.PARTITION_INDEX(2), .LBA_WIDTH(32)) dut2 (
      .Clock(clk), .sys_rst_n(rst_n), .start(start2), .byte_valid(byte_valid),
      .byte_addr(byte_addr), .byte_data(byte_data), .sector_done(sector_done),
      .read_req(read_req2), .read_lba(read_lba2), .partition_lba(part_lba2),
      .fat_lba(fat_lba2), .root_dir_lba(root_lba2), .sectors_per_cluster(spc2),
      .root_cluster(rootc2), .ready(ready2), .error(error2), .err_code(err_code2)
   );

   typedef struct {
      logic        full;
      logic        rdy;
      logic        err;
      logic [1:0]  code;
      logic [31:0] part;
      logic [31:0] fat;
      logic [31:0] root;
      logic [7:0]  spc;
      logic [31:0] rootc;
   } result_t;

   result_t     exp_res_q[$];
   logic [31:0] exp_lba_q[$];
   logic [31:0] exp_lba2_q[$];
   logic [7:0]  sec[512];
   int          n_checks = 0;
   int          n_errors = 0;
   int          req_cnt  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (read_req === 1'b1) begin
         req_cnt++;
         if (exp_lba_q.size() == 0) check_eq("read_req_unexpected", 64'(read_req), 64'd0);
         else check_eq("read_lba", 64'(read_lba), 64'(exp_lba_q.pop_front()));
      end
      if (read_req2 === 1'b1) begin
         if (exp_lba2_q.size() == 0) check_eq("read_req2_unexpected", 64'(read_req2), 64'd0);
         else check_eq("read_lba2", 64'(read_lba2), 64'(exp_lba2_q.pop_front()));
      end
   end

   task automatic put32(input int off, input logic [31:0] v);
      for (int b = 0; b < 4; b++) sec[off + b] = v[8*b +: 8];
   endtask

   task automatic clear_sec();
      for (int i = 0; i < 512; i++) sec[i] = 8'h00;
      sec[510] = 8'h55;
      sec[511] = 8'hAA;
   endtask

   task automatic build_mbr(input int idx, input logic [31:0] lba);
      clear_sec();
      sec[0] = 8'h33;
      put32(446 + 16 * idx + 8, lba);
   endtask

   task automatic build_bpb(input logic [7:0] b0, input logic [7:0] spc_v, input logic [15:0] rsvd,
                            input logic [7:0] nfat, input logic [31:0] fatsz,
                            input logic [31:0] rc);
      clear_sec();
      sec[0]  = b0;
      sec[1]  = 8'h58;
      sec[2]  = 8'h90;
      sec[11] = 8'h00;
      sec[12] = 8'h02;
      sec[13] = spc_v;
      sec[14] = rsvd[7:0];
      sec[15] = rsvd[15:8];
      sec[16] = nfat;
      put32(36, fatsz);
      put32(44, rc);
   endtask

   // Byte 0x10 (FAT count) is sent last, together with sector_done when done is set.
   task automatic stream(input int n, input bit done);
      for (int j = 0; j < n; j++) begin
         byte_valid  = 1'b1;
         byte_addr   = (j == 511) ? 9'h010 : ((j >= 16) ? 9'(j + 1) : 9'(j));
         byte_data   = sec[byte_addr];
         sector_done = done && (j == n - 1);
         @(posedge clk);
         #1;
      end
      byte_valid  = 1'b0;
      sector_done = 1'b0;
   endtask

   task automatic push_ok(input logic [31:0] part, input logic [15:0] rsvd, input logic [7:0] nfat,
                          input logic [31:0] fatsz, input logic [7:0] spc_v,
                          input logic [31:0] rc);
      result_t r;
      r.full  = 1'b1;
      r.rdy   = 1'b1;
      r.err   = 1'b0;
      r.code  = 2'b00;
      r.part  = part;
      r.fat   = part + 32'(rsvd);
      r.root  = r.fat + 32'(nfat) * fatsz;
      r.spc   = spc_v;
      r.rootc = rc;
      exp_res_q.push_back(r);
   endtask

   task automatic push_err(input logic [1:0] code);
      result_t r;
      r.full  = 1'b0;
      r.rdy   = 1'b0;
      r.err   = 1'b1;
      r.code  = code;
      r.part  = '0;
      r.fat   = '0;
      r.root  = '0;
      r.spc   = '0;
      r.rootc = '0;
      exp_res_q.push_back(r);
   endtask

   task automatic begin_run();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("start_clears_ready", 64'(ready), 64'd0);
      check_eq("start_clears_error", 64'(error), 64'd0);
      check_eq("start_clears_err_code", 64'(err_code), 64'd0);
   endtask

   task automatic wait_req(input bit second);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if ((second ? read_req2 : read_req) === 1'b1) break;
      end
      check_eq("read_req_seen", 64'(second ? read_req2 : read_req), 64'd1);
   endtask

   task automatic finish_run();
      result_t r;
      int      cyc;
      for (cyc = 1; cyc <= 60; cyc++) begin
         @(posedge clk);
         #1;
         if (ready === 1'b1 || error === 1'b1) break;
      end
      check_eq("done_seen", 64'(ready | error), 64'd1);
      r = exp_res_q.pop_front();
      if (r.rdy) check_eq("ready_latency", 64'(cyc), 64'd10);
      check_eq("ready", 64'(ready), 64'(r.rdy));
      check_eq("error", 64'(error), 64'(r.err));
      check_eq("err_code", 64'(err_code), 64'(r.code));
      if (r.full) begin
         check_eq("partition_lba", 64'(part_lba), 64'(r.part));
         check_eq("fat_lba", 64'(fat_lba), 64'(r.fat));
         check_eq("root_dir_lba", 64'(root_lba), 64'(r.root));
         check_eq("sectors_per_cluster", 64'(spc), 64'(r.spc));
         check_eq("root_cluster", 64'(rootc), 64'(r.rootc));
      end
   endtask

   task automatic check_zero(input string pfx);
      check_eq({pfx, "_read_req"}, 64'(read_req), 64'd0);
      check_eq({pfx, "_read_lba"}, 64'(read_lba), 64'd0);
      check_eq({pfx, "_partition_lba"}, 64'(part_lba), 64'd0);
      check_eq({pfx, "_fat_lba"}, 64'(fat_lba), 64'd0);
      check_eq({pfx, "_root_dir_lba"}, 64'(root_lba), 64'd0);
      check_eq({pfx, "_spc"}, 64'(spc), 64'd0);
      check_eq({pfx, "_root_cluster"}, 64'(rootc), 64'd0);
      check_eq({pfx, "_ready"}, 64'(ready), 64'd0);
      check_eq({pfx, "_error"}, 64'(error), 64'd0);
      check_eq({pfx, "_err_code"}, 64'(err_code), 64'd0);
   endtask

   initial begin
      int req_mark;
      int cyc;
      rst_n       = 1'b0;
      start       = 1'b0;
      start2      = 1'b0;
      byte_valid  = 1'b0;
      byte_addr   = '0;
      byte_data   = '0;
      sector_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;

      // MBR at sector 0 pointing to 0x2000, then the BPB there
      exp_lba_q.push_back(32'h0);
      exp_lba_q.push_back(32'h2000);
      push_ok(32'h2000, 16'h20, 8'd2, 32'h3C1, 8'd8, 32'd2);
      begin_run();
      wait_req(1'b0);
      build_mbr(0, 32'h2000);
      stream(512, 1'b1);
      wait_req(1'b0);
      build_bpb(8'hEB, 8'd8, 16'h20, 8'd2, 32'h3C1, 32'd2);
      stream(512, 1'b1);
      finish_run();

      // Bytes and sector_done while in DONE change nothing
      byte_valid  = 1'b1;
      byte_addr   = 9'h00D;
      byte_data   = 8'h00;
      sector_done = 1'b1;
      @(posedge clk);
      #1;
      byte_valid  = 1'b0;
      sector_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("idle_spc_hold", 64'(spc), 64'd8);
      check_eq("idle_ready_hold", 64'(ready), 64'd1);
      check_eq("idle_fat_hold", 64'(fat_lba), 64'h2020);

      // Bare boot sector at LBA 0
      exp_lba_q.push_back(32'h0);
      push_ok(32'h0, 16'h20, 8'd2, 32'h3C1, 8'd16, 32'd5);
      begin_run();
      wait_req(1'b0);
      build_bpb(8'hEB, 8'd16, 16'h20, 8'd2, 32'h3C1, 32'd5);
      stream(512, 1'b1);
      finish_run();

      // FAT count of zero
      exp_lba_q.push_back(32'h0);
      push_err(2'b11);
      begin_run();
      wait_req(1'b0);
      build_bpb(8'hEB, 8'd8, 16'h20, 8'd0, 32'h3C1, 32'd2);
      stream(512, 1'b1);
      finish_run();

      // Sectors per cluster of zero
      exp_lba_q.push_back(32'h0);
      push_err(2'b11);
      begin_run();
      wait_req(1'b0);
      build_bpb(8'hE9, 8'd0, 16'h20, 8'd2, 32'h3C1, 32'd2);
      stream(512, 1'b1);
      finish_run();

      // Bad signature byte at 0x1FF
      exp_lba_q.push_back(32'h0);
`ifdef FAT32_SIGNATURE_CHECK_EN
      push_err(2'b01);
`else
      push_ok(32'h0, 16'h20, 8'd2, 32'h3C1, 8'd8, 32'd2);
`endif
      begin_run();
      wait_req(1'b0);
      build_bpb(8'hE9, 8'd8, 16'h20, 8'd2, 32'h3C1, 32'd2);
      sec[511] = 8'h00;
      stream(512, 1'b1);
      finish_run();

      // Restart mid-BPB, then reset mid-CALC
      exp_lba_q.push_back(32'h0);
      exp_lba_q.push_back(32'h2000);
      exp_lba_q.push_back(32'h0);
      exp_lba_q.push_back(32'h2000);
      begin_run();
      wait_req(1'b0);
      build_mbr(0, 32'h2000);
      stream(512, 1'b1);
      wait_req(1'b0);
      build_bpb(8'hEB, 8'd8, 16'h20, 8'd2, 32'h3C1, 32'd2);
      stream(100, 1'b0);
      begin_run();
      wait_req(1'b0);
      build_mbr(0, 32'h2000);
      stream(512, 1'b1);
      wait_req(1'b0);
      build_bpb(8'hEB, 8'd8, 16'h20, 8'd2, 32'h3C1, 32'd2);
      stream(512, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check_eq("mid_calc_ready", 64'(ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check_zero("abort");
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      req_mark = req_cnt;
      repeat (30) @(posedge clk);
      #1;
      check_eq("no_req_after_reset", 64'(req_cnt), 64'(req_mark));
      check_eq("ready_after_reset", 64'(ready), 64'd0);
      check_eq("lba_queue_drained", 64'(exp_lba_q.size()), 64'd0);

      // Partition index 2 on the second instance
      exp_lba2_q.push_back(32'h0);
      exp_lba2_q.push_back(32'h12345678);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      wait_req(1'b1);
      build_mbr(0, 32'h2000);
      put32(446 + 32 + 8, 32'h12345678);
      stream(512, 1'b1);
      wait_req(1'b1);
      build_bpb(8'hEB, 8'd8, 16'h20, 8'd2, 32'h3C1, 32'd2);
      stream(512, 1'b1);
      for (cyc = 1; cyc <= 60; cyc++) begin
         @(posedge clk);
         #1;
         if (ready2 === 1'b1 || error2 === 1'b1) break;
      end
      check_eq("p2_ready", 64'(ready2), 64'd1);
      check_eq("p2_ready_latency", 64'(cyc), 64'd10);
      check_eq("p2_partition_lba", 64'(part_lba2), 64'h12345678);
      check_eq("p2_fat_lba", 64'(fat_lba2), 64'(32'h12345678 + 32'h20));
      check_eq("p2_root_dir_lba", 64'(root_lba2), 64'(32'h12345678 + 32'h20 + 32'd2 * 32'h3C1));
      check_eq("idle_partition_lba", 64'(part_lba), 64'd0);
      check_eq("lba2_queue_drained", 64'(exp_lba2_q.size()), 64'd0);
      check_eq("result_queue_drained", 64'(exp_res_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
